rlen_partition: RTL and testbench



---
 rtl/rlen_partition.sv | 126 ++++++++++++
 tb/tb_rlen_partition.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rlen_partition.sv
// rlen_partition: splits one DMA read command (start address + byte length) into AXI4 INCR
// read-address bursts that never cross a 4 KB boundary and never exceed MAX_BURST beats.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   cfg_dmar_valid    command valid
//   cfg_dmar_ready    command ready (registered, high in every idle cycle)
//   cfg_dmar_sa       command start byte address
//   cfg_dmar_len      command length in bytes
//   arid/araddr/arlen/arsize/arburst/arvalid/arready
//                     AXI read-address channel (master side)
module rlen_partition #(
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned AXI_AW     = 32,
  parameter int unsigned AXI_IW     = 8,
  parameter int unsigned AXI_LW     = 8,
  parameter int unsigned AXI_SW     = 3,
  parameter int unsigned AXI_BURSTW = 2,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned ARID_VAL   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_dmar_valid,
  output logic                  cfg_dmar_ready,
  input  logic [31:0]           cfg_dmar_sa,
  input  logic [31:0]           cfg_dmar_len,
  output logic [AXI_IW-1:0]     arid,
  output logic [AXI_AW-1:0]     araddr,
  output logic [AXI_LW-1:0]     arlen,
  output logic [AXI_SW-1:0]     arsize,
  output logic [AXI_BURSTW-1:0] arburst,
  output logic                  arvalid,
  input  logic                  arready
);

  localparam int unsigned AxiBytes = AXI_DW / 8;
  localparam int unsigned ByteLog  = $clog2(AxiBytes);
  // Beat counts up to MAX_BURST (<= 2^AXI_LW) need one bit more than arlen.
  localparam int unsigned BeatW    = AXI_LW + 1;

  localparam logic [AXI_AW-1:0] LowMask   = AXI_AW'(AxiBytes - 1);
  localparam logic [12:0]       MaxBurst13 = 13'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StCalc, StAddr} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              arvalid_q;
  logic [AXI_AW-1:0] araddr_q;
  logic [AXI_LW-1:0] arlen_q;
  logic [AXI_AW-1:0] addr_q;
  // 33 bits so that a length near 2^32 rounds up without overflowing.
  logic [32:0]       rem_q;

  logic [32:0]       rem_init;
  logic [12:0]       to4k;
  logic [12:0]       cap;
  logic [BeatW-1:0]  beats;
  logic [BeatW-1:0]  hs_beats;

  always_comb begin
    rem_init = ({1'b0, cfg_dmar_len} + 33'(AxiBytes - 1)) >> ByteLog;
    // Beats left before the next 4 KB boundary; an address wrap to 0 lands on one anyway.
    to4k     = (13'h1000 - {1'b0, addr_q[11:0]}) >> ByteLog;
    cap      = (to4k < MaxBurst13) ? to4k : MaxBurst13;
    beats    = (rem_q < 33'(cap)) ? rem_q[BeatW-1:0] : BeatW'(cap);
    // Length of the burst currently on the bus, recovered from arlen.
    hs_beats = {1'b0, arlen_q} + BeatW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ready_q && cfg_dmar_valid) begin
            addr_q  <= cfg_dmar_sa[AXI_AW-1:0] & ~LowMask;
            rem_q   <= rem_init;
            ready_q <= 1'b0;
            state_q <= StCalc;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StCalc: begin
          if (rem_q == '0) begin
            // Raise ready on the same edge we re-enter idle.
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            araddr_q  <= addr_q;
            arlen_q   <= AXI_LW'(beats - BeatW'(1));
            arvalid_q <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            addr_q    <= addr_q + (AXI_AW'(hs_beats) << ByteLog);
            rem_q     <= rem_q - 33'(hs_beats);
            state_q   <= StCalc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_dmar_ready = ready_q;
  assign arvalid        = arvalid_q;
  assign araddr         = araddr_q;
  assign arlen          = arlen_q;
  assign arid           = AXI_IW'(ARID_VAL);
  assign arsize         = AXI_SW'(ByteLog);
  assign arburst        = AXI_BURSTW'(1);

endmodule

// File: tb/tb_rlen_partition.sv
// Bench for rlen_partition: directed table, hand-written reset/backpressure sequences and
// randomized commands checked against a burst-list reference model.
module tb_rlen_partition;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_dmar_valid = 1'b0;
  logic        cfg_dmar_ready;
  logic [31:0] cfg_dmar_sa = '0;
  logic [31:0] cfg_dmar_len = '0;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;

  always #5 clk = ~clk;

  rlen_partition #(
    .AXI_DW    (128),
    .AXI_AW    (32),
    .AXI_IW    (8),
    .AXI_LW    (8),
    .AXI_SW    (3),
    .AXI_BURSTW(2),
    .MAX_BURST (256),
    .ARID_VAL  (0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_dmar_valid(cfg_dmar_valid),
    .cfg_dmar_ready(cfg_dmar_ready),
    .cfg_dmar_sa   (cfg_dmar_sa),
    .cfg_dmar_len  (cfg_dmar_len),
    .arid          (arid),
    .araddr        (araddr),
    .arlen         (arlen),
    .arsize        (arsize),
    .arburst       (arburst),
    .arvalid       (arvalid),
    .arready       (arready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  typedef struct {
    logic [31:0] sa;
    logic [31:0] len;
    int          hold;
    bit          pulse;
    int          n;
    logic [31:0] a_first;
    logic [7:0]  l_first;
    logic [31:0] a_last;
    logic [7:0]  l_last;
  } vec_t;

  burst_t got_q[$];
  burst_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: 16-byte beats, at most 256 beats, never past a 4 KB boundary.
  function automatic void model(input logic [31:0] sa, input logic [31:0] len);
    longint unsigned addr, rem, to4k, b;
    exp_q.delete();
    addr = 64'(sa & 32'hFFFF_FFF0);
    rem  = (64'(len) + 64'd15) / 64'd16;
    while (rem > 0) begin
      to4k = (64'd4096 - (addr % 64'd4096)) / 64'd16;
      b = rem;
      if (b > 64'd256) b = 64'd256;
      if (b > to4k) b = to4k;
      exp_q.push_back(burst_t'{addr[31:0], 8'(b - 64'd1)});
      addr = (addr + b * 64'd16) % (64'd1 << 32);
      rem  = rem - b;
    end
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!cfg_dmar_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready", 64'(cfg_dmar_ready), 64'd1);
  endtask

  // Issues one command and collects the bursts it produces into got_q.
  task automatic run_cmd(input logic [31:0] sa, input logic [31:0] len, input int bp_pct,
                         input int hold_n, input bit pulse);
    bit          held = 1'b0;
    bit          done = 1'b0;
    int          low_run = 0;
    int          hold_cnt = 0;
    logic [31:0] h_addr = '0;
    logic [7:0]  h_len = '0;
    got_q.delete();
    wait_ready();
    cfg_dmar_valid = 1'b1;
    cfg_dmar_sa    = sa;
    cfg_dmar_len   = len;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      cfg_dmar_valid = pulse && (cyc == 3);
      if (cfg_dmar_valid) begin
        cfg_dmar_sa  = 32'h9000;
        cfg_dmar_len = 32'h100;
      end
      if (cfg_dmar_ready) begin
        done = 1'b1;
        break;
      end
      if (arvalid) begin
        if (held) begin
          check("hold_araddr", 64'(araddr), 64'(h_addr));
          check("hold_arlen", 64'(arlen), 64'(h_len));
        end else begin
          check("burst_gap", 64'(low_run), 64'd1);
        end
        check("arsize", 64'(arsize), 64'd4);
        check("arburst", 64'(arburst), 64'd1);
        check("arid", 64'(arid), 64'd0);
        low_run = 0;
        if (hold_cnt < hold_n) begin
          arready = 1'b0;
          hold_cnt++;
        end else begin
          arready = ($urandom_range(99) >= 32'(bp_pct));
        end
        if (arready) got_q.push_back(burst_t'{araddr, arlen});
        held   = !arready;
        h_addr = araddr;
        h_len  = arlen;
      end else begin
        if (held) check("arvalid_held", 64'(arvalid), 64'd1);
        held = 1'b0;
        low_run++;
        arready = 1'($urandom_range(1));
      end
    end
    arready        = 1'b0;
    cfg_dmar_valid = 1'b0;
    check("cmd_done", 64'(done), 64'd1);
    if (done) check("ready_gap", 64'(low_run), 64'd1);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_len"}, 64'(got_q[i].len), 64'(exp_q[i].len));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[8];
    int          w;
    logic [31:0] r_sa, r_len;
    int          r_bp;

    tbl[0] = '{32'h0000_1000, 32'h100, 0, 1'b0, 1, 32'h1000, 8'd15, 32'h1000, 8'd15};
    tbl[1] = '{32'h0000_0FF0, 32'h40, 0, 1'b0, 2, 32'h0FF0, 8'd0, 32'h1000, 8'd2};
    tbl[2] = '{32'h0000_2008, 32'h2001, 0, 1'b0, 3, 32'h2000, 8'd255, 32'h4000, 8'd0};
    tbl[3] = '{32'h0000_3000, 32'h0, 0, 1'b0, 0, 32'h0, 8'd0, 32'h0, 8'd0};
    tbl[4] = '{32'h0000_1000, 32'h100, 5, 1'b1, 1, 32'h1000, 8'd15, 32'h1000, 8'd15};
    tbl[5] = '{32'hFFFF_FF00, 32'h200, 0, 1'b0, 2, 32'hFFFF_FF00, 8'd15, 32'h0, 8'd15};
    tbl[6] = '{32'h0000_0FFF, 32'h1, 0, 1'b0, 1, 32'h0FF0, 8'd0, 32'h0FF0, 8'd0};
    tbl[7] = '{32'h0000_0000, 32'h2000, 0, 1'b0, 2, 32'h0, 8'd255, 32'h1000, 8'd255};

    // Reset state
    #2;
    check("rst_ready", 64'(cfg_dmar_ready), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_arsize", 64'(arsize), 64'd4);
    check("rst_arburst", 64'(arburst), 64'd1);
    check("rst_arid", 64'(arid), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cfg_dmar_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].sa, tbl[i].len, 0, tbl[i].hold, tbl[i].pulse);
      check("tbl_count", 64'(got_q.size()), 64'(tbl[i].n));
      if (tbl[i].n > 0 && got_q.size() > 0) begin
        check("tbl_first_addr", 64'(got_q[0].addr), 64'(tbl[i].a_first));
        check("tbl_first_len", 64'(got_q[0].len), 64'(tbl[i].l_first));
        check("tbl_last_addr", 64'(got_q[$].addr), 64'(tbl[i].a_last));
        check("tbl_last_len", 64'(got_q[$].len), 64'(tbl[i].l_last));
      end
    end

    // Reset in the middle of a 3-burst command
    wait_ready();
    cfg_dmar_valid = 1'b1;
    cfg_dmar_sa    = 32'h2008;
    cfg_dmar_len   = 32'h2001;
    arready        = 1'b0;
    @(negedge clk);
    cfg_dmar_valid = 1'b0;
    w = 0;
    while (!arvalid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("mid_arvalid_seen", 64'(arvalid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check("mid_rst_ready", 64'(cfg_dmar_ready), 64'd0);
    check("mid_rst_araddr", 64'(araddr), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_ready_after", 64'(cfg_dmar_ready), 64'd1);
    run_cmd(32'h5000, 32'h10, 0, 0, 1'b0);
    check("post_rst_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      check("post_rst_addr", 64'(got_q[0].addr), 64'h5000);
      check("post_rst_len", 64'(got_q[0].len), 64'd0);
    end

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      r_sa  = $urandom;
      r_len = (i % 8 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 12000));
      r_bp  = int'($urandom_range(0, 60));
      model(r_sa, r_len);
      run_cmd(r_sa, r_len, r_bp, 0, 1'b0);
      cmp_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
